// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared opcode and FSM state encodings for the sequential ALU.
//             aluop_e  - 5-bit operation codes (0x00-0x11 defined).
//             state_e  - top-level control FSM states.
//             c_RSVD_* - bounds of the reserved opcode range.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [4:0] {
        OP_AND  = 5'h00,
        OP_OR   = 5'h01,
        OP_XOR  = 5'h02,
        OP_NAND = 5'h03,
        OP_NOT  = 5'h04,
        OP_SLL  = 5'h05,
        OP_SRL  = 5'h06,
        OP_SRA  = 5'h07,
        OP_MULU = 5'h08,
        OP_MUL  = 5'h09,
        OP_ADD  = 5'h0A,
        OP_ADDU = 5'h0B,
        OP_SUB  = 5'h0C,
        OP_SUBU = 5'h0D,
        OP_SLT  = 5'h0E,
        OP_SLTU = 5'h0F,
        OP_DIVU = 5'h10,
        OP_DIV  = 5'h11
    } aluop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Opcodes in this range complete in one cycle with all-zero results.
    localparam logic [4:0] c_RSVD_LO = 5'h12;
    localparam logic [4:0] c_RSVD_HI = 5'h1F;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_iter
//  Purpose  : Iterative N-step shift-add multiplier / restoring divider.
//             Works on operand magnitudes and applies the sign fix-up on the
//             final step. The divider is only built when ALU_SEQ_DIV_EN is
//             defined.
//  Ports    : clk, rst_n (sync, active-low)
//             start      - load operands, begin N iterations
//             is_div     - 1: divide, 0: multiply
//             is_signed  - signed (MUL/DIV) vs unsigned (MULU/DIVU)
//             a, b       - operands, sampled on start only
//             done       - high during the final iteration cycle; res_* and
//                          ov are valid in that cycle
//             res_lo/hi  - product low/high or quotient/remainder
//             ov         - signed divide overflow (min / -1)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] res_lo,
    output logic [N-1:0] res_hi,
    output logic         ov
);

    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_opb;     // multiplicand / divisor magnitude
    logic [N-1:0]   r_hi;      // product high half / partial remainder
    logic [N-1:0]   r_lo;      // multiplier -> product low / dividend -> quotient
    logic           r_neg_lo;  // product (MUL) or quotient (DIV) gets negated

    logic           w_neg_a, w_neg_b;
    logic [N-1:0]   w_mag_a, w_mag_b;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_mul_hi, w_mul_lo;
    logic [N-1:0]   w_nxt_hi, w_nxt_lo;
    logic [2*N-1:0] w_prod, w_prod_fix;

    assign w_neg_a = is_signed & a[N-1];
    assign w_neg_b = is_signed & b[N-1];
    assign w_mag_a = w_neg_a ? -a : a;
    assign w_mag_b = w_neg_b ? -b : b;

    // Shift-add step: conditionally add multiplicand to the high half, then
    // shift the whole {carry, hi, lo} right by one.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_hi = w_sum[N:1];
    assign w_mul_lo = {w_sum[0], r_lo[N-1:1]};

    assign done = (r_cnt == CW'(1));

`ifdef ALU_SEQ_DIV_EN
    logic       r_div;
    logic       r_neg_hi;   // remainder takes the dividend's sign
    logic       r_bzero;
    logic       r_ovf;
    logic [N:0] w_shift, w_diff;
    logic       w_fits;
    logic [N-1:0] w_div_hi, w_div_lo;

    // Restoring step: shift next dividend bit into the remainder and keep
    // the subtraction only if it did not borrow.
    assign w_shift  = {r_hi, r_lo[N-1]};
    assign w_diff   = w_shift - {1'b0, r_opb};
    assign w_fits   = ~w_diff[N];
    assign w_div_hi = w_fits ? w_diff[N-1:0] : w_shift[N-1:0];
    assign w_div_lo = {r_lo[N-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div    <= 1'b0;
            r_neg_hi <= 1'b0;
            r_bzero  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (start) begin
            r_div    <= is_div;
            r_neg_hi <= w_neg_a;
            r_bzero  <= (b == '0);
            r_ovf    <= is_div & is_signed & (a == {1'b1, {(N-1){1'b0}}}) & (b == '1);
        end
    end

    assign w_nxt_hi = r_div ? w_div_hi : w_mul_hi;
    assign w_nxt_lo = r_div ? w_div_lo : w_mul_lo;

    // Divide by zero yields an all-ones quotient; the remainder then holds
    // |a|, and re-applying the dividend sign restores a itself.
    assign res_lo = r_div ? (r_bzero ? '1 : (r_neg_lo ? -w_nxt_lo : w_nxt_lo))
                          : w_prod_fix[N-1:0];
    assign res_hi = r_div ? (r_neg_hi ? -w_nxt_hi : w_nxt_hi)
                          : w_prod_fix[2*N-1:N];
    assign ov     = r_div & r_ovf;
`else
    logic w_unused_div;
    assign w_unused_div = is_div;

    assign w_nxt_hi = w_mul_hi;
    assign w_nxt_lo = w_mul_lo;
    assign res_lo   = w_prod_fix[N-1:0];
    assign res_hi   = w_prod_fix[2*N-1:N];
    assign ov       = 1'b0;
`endif

    assign w_prod     = {w_nxt_hi, w_nxt_lo};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_lo <= 1'b0;
        end else if (start) begin
            r_cnt    <= CW'(N);
            r_opb    <= w_mag_b;
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_neg_lo <= w_neg_a ^ w_neg_b;
        end else if (r_cnt != '0) begin
            r_cnt    <= r_cnt - CW'(1);
            r_hi     <= w_nxt_hi;
            r_lo     <= w_nxt_lo;
        end
    end

endmodule : alu_muldiv_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered multi-cycle ALU with valid/ready handshakes.
//             Single-cycle logic/shift/add ops, iterative MUL/MULU and
//             (when ALU_SEQ_DIV_EN is defined) DIV/DIVU. Without the macro,
//             0x10/0x11 behave as reserved opcodes.
//  Ports    : clk, rst_n (sync, active-low)
//             in_valid/in_ready   - request handshake (ready only in IDLE)
//             a, b, aluop         - operands and operation code
//             out_valid/out_ready - result handshake (valid only in DONE)
//             res0, res1          - result / product lo-hi / quotient-remainder
//             zero, ov            - {res1,res0}==0, signed overflow
//             busy                - unit not idle
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   aluop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res0,
    output logic [N-1:0] res1,
    output logic         zero,
    output logic         ov,
    output logic         busy
);
    import alu_seq_pkg::*;

    localparam int SHW = $clog2(N);

    state_e       r_state, w_state_nxt;
    logic [N-1:0] r_res0, r_res1;
    logic         r_zero, r_ov;

    logic           w_accept, w_is_mul, w_is_div, w_is_signed, w_md_start;
    logic           w_md_done, w_md_ov;
    logic [N-1:0]   w_md_lo, w_md_hi;
    logic [N-1:0]   w_sc_res, w_addend, w_sum;
    logic           w_sc_ov, w_add_ov, w_sub_op;
    logic [SHW-1:0] w_shamt;

    assign w_accept    = in_valid & (r_state == S_IDLE);
    assign w_is_mul    = (aluop == OP_MUL) || (aluop == OP_MULU);
`ifdef ALU_SEQ_DIV_EN
    assign w_is_div    = (aluop == OP_DIV) || (aluop == OP_DIVU);
`else
    assign w_is_div    = 1'b0;
`endif
    assign w_is_signed = (aluop == OP_MUL) || (aluop == OP_DIV);
    assign w_md_start  = w_accept & (w_is_mul | w_is_div);

    // Shared adder: subtraction adds the two's-complement of b, and overflow
    // is judged on the operands as actually presented to the adder.
    assign w_sub_op = (aluop == OP_SUB) || (aluop == OP_SUBU);
    assign w_addend = w_sub_op ? -b : b;
    assign w_sum    = a + w_addend;
    assign w_add_ov = (a[N-1] == w_addend[N-1]) && (w_sum[N-1] != a[N-1]);
    assign w_shamt  = b[SHW-1:0];

    always_comb begin
        w_sc_res = '0;
        w_sc_ov  = 1'b0;
        case (aluop)
            OP_AND:  w_sc_res = a & b;
            OP_OR:   w_sc_res = a | b;
            OP_XOR:  w_sc_res = a ^ b;
            OP_NAND: w_sc_res = ~(a & b);
            OP_NOT:  w_sc_res = ~a;
            OP_SLL:  w_sc_res = a << w_shamt;
            OP_SRL:  w_sc_res = a >> w_shamt;
            OP_SRA:  w_sc_res = $unsigned($signed(a) >>> w_shamt);
            OP_ADD, OP_SUB: begin
                w_sc_res = w_sum;
                w_sc_ov  = w_add_ov;
            end
            OP_ADDU, OP_SUBU: w_sc_res = w_sum;
            OP_SLT:  w_sc_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_sc_res = {{(N-1){1'b0}}, (a < b)};
            // MUL/DIV never take this path; reserved codes (and DIV codes
            // when the divider is absent) produce zero.
            default: ;
        endcase
    end

    alu_muldiv_iter #(
        .N (N)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_md_start),
        .is_div    (w_is_div),
        .is_signed (w_is_signed),
        .a         (a),
        .b         (b),
        .done      (w_md_done),
        .res_lo    (w_md_lo),
        .res_hi    (w_md_hi),
        .ov        (w_md_ov)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul)      w_state_nxt = S_MUL;
                    else if (w_is_div) w_state_nxt = S_DIV;
                    else               w_state_nxt = S_DONE;
                end
            end
            S_MUL, S_DIV: if (w_md_done) w_state_nxt = S_DONE;
            S_DONE:       if (out_ready) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_res0  <= '0;
            r_res1  <= '0;
            r_zero  <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !(w_is_mul || w_is_div)) begin
                r_res0 <= w_sc_res;
                r_res1 <= '0;
                r_zero <= (w_sc_res == '0);
                r_ov   <= w_sc_ov;
            end else if ((r_state == S_MUL || r_state == S_DIV) && w_md_done) begin
                r_res0 <= w_md_lo;
                r_res1 <= w_md_hi;
                r_zero <= (w_md_lo == '0) && (w_md_hi == '0);
                r_ov   <= w_md_ov;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign res0      = r_res0;
    assign res1      = r_res1;
    assign zero      = r_zero;
    assign ov        = r_ov;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (N=32). Directed vector table
//             plus hand-written reset, backpressure and back-to-back
//             sequences. DIV expectations follow ALU_SEQ_DIV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic [4:0]   aluop;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res0, res1;
    logic         zero, ov, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluop     (aluop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res0      (res0),
        .res1      (res1),
        .zero      (zero),
        .ov        (ov),
        .busy      (busy)
    );

    typedef struct {
        logic [4:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           lat;
        logic [N-1:0] r0;
        logic [N-1:0] r1;
        logic         z;
        logic         v;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [4:0] op, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input int lat, input logic [N-1:0] r0, input logic [N-1:0] r1,
                        input logic z, input logic v);
        vecs[i].op = op; vecs[i].a = va; vecs[i].b = vb; vecs[i].lat = lat;
        vecs[i].r0 = r0; vecs[i].r1 = r1; vecs[i].z = z; vecs[i].v = v;
    endtask

    task automatic wait_ready(input int idx);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", idx, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        wait_ready(idx);
        aluop = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // Operand changes after accept must not disturb the operation.
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", idx, 64'(lat), 64'(v.lat));
        chk("res0", idx, {32'd0, res0}, {32'd0, v.r0});
        chk("res1", idx, {32'd0, res1}, {32'd0, v.r1});
        chk("zero", idx, {63'd0, zero}, {63'd0, v.z});
        chk("ov", idx, {63'd0, ov}, {63'd0, v.v});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        setv( 0, 5'h00, 32'hF0F0F0F0, 32'hFF00FF00,  1, 32'hF000F000, 32'h0, 1'b0, 1'b0); // AND
        setv( 1, 5'h01, 32'hF0F0F0F0, 32'h0F0F0000,  1, 32'hFFFFF0F0, 32'h0, 1'b0, 1'b0); // OR
        setv( 2, 5'h02, 32'hFFFF0000, 32'h0F0F0F0F,  1, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0); // XOR
        setv( 3, 5'h03, 32'hFFFFFFFF, 32'h0000FFFF,  1, 32'hFFFF0000, 32'h0, 1'b0, 1'b0); // NAND
        setv( 4, 5'h04, 32'h12345678, 32'h0,         1, 32'hEDCBA987, 32'h0, 1'b0, 1'b0); // NOT
        setv( 5, 5'h05, 32'h00000001, 32'd31,        1, 32'h80000000, 32'h0, 1'b0, 1'b0); // SLL
        setv( 6, 5'h06, 32'h80000000, 32'd4,         1, 32'h08000000, 32'h0, 1'b0, 1'b0); // SRL
        setv( 7, 5'h07, 32'h80000000, 32'd4,         1, 32'hF8000000, 32'h0, 1'b0, 1'b0); // SRA
        setv( 8, 5'h0A, 32'h7FFFFFFF, 32'd1,         1, 32'h80000000, 32'h0, 1'b0, 1'b1); // ADD ov
        setv( 9, 5'h0B, 32'h7FFFFFFF, 32'd1,         1, 32'h80000000, 32'h0, 1'b0, 1'b0); // ADDU
        setv(10, 5'h0C, 32'h80000000, 32'd1,         1, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1); // SUB ov
        setv(11, 5'h0D, 32'd5,        32'd5,         1, 32'h0,        32'h0, 1'b1, 1'b0); // SUBU
        setv(12, 5'h0E, 32'hFFFFFFFF, 32'd1,         1, 32'd1,        32'h0, 1'b0, 1'b0); // SLT
        setv(13, 5'h0F, 32'hFFFFFFFF, 32'd1,         1, 32'd0,        32'h0, 1'b1, 1'b0); // SLTU
        setv(14, 5'h09, 32'hFFFFFFFD, 32'd7,        33, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0); // MUL
        setv(15, 5'h08, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0); // MULU
        setv(16, 5'h09, 32'h80000000, 32'h80000000, 33, 32'h0,        32'h40000000, 1'b0, 1'b0); // MUL min*min
        setv(17, 5'h15, 32'h12345678, 32'h9ABCDEF0,  1, 32'h0,        32'h0, 1'b1, 1'b0); // reserved
`ifdef ALU_SEQ_DIV_EN
        setv(18, 5'h11, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0); // -7/2
        setv(19, 5'h10, 32'd5,        32'd0,        33, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b0);        // 5/0
        setv(20, 5'h11, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0, 1'b0, 1'b1);        // min/-1
        setv(21, 5'h10, 32'd100,      32'd7,        33, 32'd14,       32'd2, 1'b0, 1'b0);        // 100/7
        setv(22, 5'h11, 32'd7,        32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0);        // 7/-2
        setv(23, 5'h11, 32'hFFFFFFFB, 32'd0,        33, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0); // -5/0
`else
        setv(18, 5'h11, 32'hFFFFFFF9, 32'd2,         1, 32'h0, 32'h0, 1'b1, 1'b0);
        setv(19, 5'h10, 32'd5,        32'd0,         1, 32'h0, 32'h0, 1'b1, 1'b0);
        setv(20, 5'h11, 32'h80000000, 32'hFFFFFFFF,  1, 32'h0, 32'h0, 1'b1, 1'b0);
        setv(21, 5'h10, 32'd100,      32'd7,         1, 32'h0, 32'h0, 1'b1, 1'b0);
        setv(22, 5'h11, 32'd7,        32'hFFFFFFFE,  1, 32'h0, 32'h0, 1'b1, 1'b0);
        setv(23, 5'h11, 32'hFFFFFFFB, 32'd0,         1, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        // ---------------- reset / idle ----------------
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; aluop = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 0, {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", 0, {63'd0, out_valid}, 64'd0);
        chk("rst_res0", 0, {32'd0, res0}, 64'd0);
        chk("rst_res1", 0, {32'd0, res1}, 64'd0);
        chk("rst_busy", 0, {63'd0, busy}, 64'd0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 24; i++) run_vec(i, vecs[i]);

        // ---------------- backpressure ----------------
        @(negedge clk);
        wait_ready(100);
        aluop = 5'h0A; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid0", 100, {63'd0, out_valid}, 64'd1);
        chk("bp_res0", 100, {32'd0, res0}, 64'd7);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; aluop = 5'h01; a = 32'(i + 100); b = 32'h0000FFFF;
            @(negedge clk);
            chk("bp_valid", 101 + i, {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", 101 + i, {63'd0, in_ready}, 64'd0);
            chk("bp_hold_res0", 101 + i, {32'd0, res0}, 64'd7);
            chk("bp_hold_res1", 101 + i, {32'd0, res1}, 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", 110, {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", 110, {63'd0, in_ready}, 64'd1);
        chk("bp_not_taken", 110, {32'd0, res0}, 64'd7);

        // ---------------- back-to-back single-cycle ----------------
        begin
            logic [4:0]   bop[3];
            logic [N-1:0] ba[3], bb[3], bexp[3];
            bop[0] = 5'h00; ba[0] = 32'h0F0F00FF; bb[0] = 32'h00FF0F0F; bexp[0] = 32'h000F000F;
            bop[1] = 5'h05; ba[1] = 32'h40000001; bb[1] = 32'd33;       bexp[1] = 32'h80000002;
            bop[2] = 5'h0F; ba[2] = 32'd1;        bb[2] = 32'd2;        bexp[2] = 32'd1;
            @(negedge clk);
            out_ready = 1'b1;
            aluop = bop[0]; a = ba[0]; b = bb[0]; in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("b2b_valid", 200 + i, {63'd0, out_valid}, 64'd1);
                chk("b2b_res0", 200 + i, {32'd0, res0}, {32'd0, bexp[i]});
                if (i < 2) begin
                    aluop = bop[i+1]; a = ba[i+1]; b = bb[i+1];
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                chk("b2b_gap", 200 + i, {63'd0, out_valid}, 64'd0);
            end
            out_ready = 1'b0;
        end

        // ---------------- reset in the middle of a MUL ----------------
        @(negedge clk);
        wait_ready(300);
        aluop = 5'h09; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_mul_busy", 300, {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("abort_no_valid", 300, 64'(seen), 64'd0);
        end
        out_ready = 1'b0;
        chk("abort_in_ready", 300, {63'd0, in_ready}, 64'd1);
        chk("abort_res0", 300, {32'd0, res0}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
